// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings common to the
// multiplier and divider, plus the default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SUB   = 2'b10,
        FIX   = 2'b11
    } state_t;

endpackage

// File: rtl/booth_divider_if.sv
// Request/result bundle of the signed divider: operands and start in,
// quotient/remainder/status out.
interface booth_divider_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             ovf;

    modport master (
        output start, dvd, dvs,
        input  quo, rem, busy, done, div_zero, ovf
    );

    modport slave (
        input  start, dvd, dvs,
        output quo, rem, busy, done, div_zero, ovf
    );

endinterface

// File: rtl/twos_abs.sv
// Conditional two's-complement negate; with neg tied to the operand sign
// it yields the unsigned magnitude (most-negative maps to 2^(WIDTH-1)).
module twos_abs #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? (~in_val + 1'b1) : in_val;

endmodule

// File: rtl/booth_divider.sv
// Signed restoring divider, C semantics (truncate toward zero, remainder
// follows dividend); 2*WIDTH+2 cycles per op, divide-by-zero in 2 cycles.
module booth_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clock,
    input  logic           reset_n,
    booth_divider_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic             ovf_n_q, ovf_n_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    twos_abs #(.WIDTH(WIDTH)) u_abs_dvd (
        .in_val (bus.dvd),
        .neg    (bus.dvd[WIDTH-1]),
        .out_val(dvd_mag)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_dvs (
        .in_val (bus.dvs),
        .neg    (bus.dvs[WIDTH-1]),
        .out_val(dvs_mag)
    );

    twos_abs #(.WIDTH(WIDTH)) u_neg_quo (
        .in_val (q_q),
        .neg    (sgn_quo_q),
        .out_val(quo_fix)
    );

    twos_abs #(.WIDTH(WIDTH)) u_neg_rem (
        .in_val (r_q[WIDTH-1:0]),
        .neg    (sgn_rem_q),
        .out_val(rem_fix)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        sgn_quo_d  = sgn_quo_q;
        sgn_rem_d  = sgn_rem_q;
        ovf_n_d    = ovf_n_q;
        dz_d       = dz_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    r_d   = '0;
                    cnt_d = '0;
                    if (bus.dvs == '0) begin
                        // Q keeps the raw dividend so FIX can return it as the remainder
                        q_d       = bus.dvd;
                        dz_d      = 1'b1;
                        ovf_n_d   = 1'b0;
                        sgn_quo_d = 1'b0;
                        sgn_rem_d = 1'b0;
                        state_d   = FIX;
                    end else begin
                        q_d       = dvd_mag;
                        d_d       = dvs_mag;
                        dz_d      = 1'b0;
                        sgn_quo_d = bus.dvd[WIDTH-1] ^ bus.dvs[WIDTH-1];
                        sgn_rem_d = bus.dvd[WIDTH-1];
                        ovf_n_d   = (bus.dvd == MOST_NEG) && (bus.dvs == '1);
                        state_d   = SHIFT;
                    end
                end
            end

            SHIFT: begin
                r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = {q_q[WIDTH-2:0], 1'b0};
                state_d = SUB;
            end

            SUB: begin
                if (r_q >= {1'b0, d_q}) begin
                    r_d = r_q - {1'b0, d_q};
                    q_d = {q_q[WIDTH-1:1], 1'b1};
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_CNT) ? FIX : SHIFT;
            end

            FIX: begin
                if (dz_q) begin
                    quo_d = '1;
                    rem_d = q_q;
                end else if (ovf_n_q) begin
                    quo_d = MOST_NEG;
                    rem_d = '0;
                end else begin
                    quo_d = quo_fix;
                    rem_d = rem_fix;
                end
                div_zero_d = dz_q;
                ovf_d      = ovf_n_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            sgn_quo_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
            ovf_n_q    <= 1'b0;
            dz_q       <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            sgn_quo_q  <= sgn_quo_d;
            sgn_rem_q  <= sgn_rem_d;
            ovf_n_q    <= ovf_n_d;
            dz_q       <= dz_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.quo      = quo_q;
    assign bus.rem      = rem_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboarded bench for booth_divider at WIDTH=4: expected results come
// from C-semantics integer division and are popped on each done pulse.
module tb_booth_divider;
    import arith_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    booth_divider_if #(.WIDTH(W)) bus ();

    booth_divider #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        sa    = $signed(a);
        sb    = $signed(b);
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (sb == 0) begin
            e.quo = 4'b1111;
            e.rem = a;
            e.dz  = 1'b1;
        end else if (sa == -8 && sb == -1) begin
            e.quo = 4'b1000;
            e.rem = 4'b0000;
            e.ovf = 1'b1;
        end else begin
            e.quo = 4'(sa / sb);
            e.rem = 4'(sa % sb);
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && bus.done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 with no outstanding request, want done=0");
            end else begin
                e = sb_q.pop_front();
                checks += 4;
                if (bus.quo !== e.quo) begin
                    errors++;
                    $display("FAIL sb_quo: got %b want %b", bus.quo, e.quo);
                end
                if (bus.rem !== e.rem) begin
                    errors++;
                    $display("FAIL sb_rem: got %b want %b", bus.rem, e.rem);
                end
                if (bus.div_zero !== e.dz) begin
                    errors++;
                    $display("FAIL sb_div_zero: got %b want %b", bus.div_zero, e.dz);
                end
                if (bus.ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL sb_ovf: got %b want %b", bus.ovf, e.ovf);
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                         input string tag);
        int n;
        bit seen;
        @(negedge clock);
        bus.dvd   = a;
        bus.dvs   = b;
        bus.start = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clock);
        #1 bus.start = 1'b0;
        bus.dvd = ~a;
        bus.dvs = ~b;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_after_accept: got %b want 1", tag, bus.busy);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clock);
            #1 n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges (seen=%0d) want %0d", tag, n, seen, exp_lat);
        end
        if (seen) begin
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_on_done: got %b want 0", tag, bus.busy);
            end
            @(posedge clock);
            #1 checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_width: got done=%b one cycle later, want 0", tag, bus.done);
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        repeat (2) @(posedge clock);
        #1 checks += 6;
        if (bus.quo !== 4'b0000) begin errors++; $display("FAIL rst_quo: got %b want 0000", bus.quo); end
        if (bus.rem !== 4'b0000) begin errors++; $display("FAIL rst_rem: got %b want 0000", bus.rem); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL rst_dz: got %b want 0", bus.div_zero); end
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1 checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        do_op(4'd7, 4'd2, 2 * W + 1, "basic_7_2");
        checks += 2;
        if (bus.quo !== 4'b0011) begin errors++; $display("FAIL basic_quo: got %b want 0011", bus.quo); end
        if (bus.rem !== 4'b0001) begin errors++; $display("FAIL basic_rem: got %b want 0001", bus.rem); end
    endtask

    task automatic test_signs();
        do_op(4'b1001, 4'd2, 2 * W + 1, "neg_dvd");
        checks += 2;
        if (bus.quo !== 4'b1101) begin errors++; $display("FAIL negdvd_quo: got %b want 1101", bus.quo); end
        if (bus.rem !== 4'b1111) begin errors++; $display("FAIL negdvd_rem: got %b want 1111", bus.rem); end
        do_op(4'd7, 4'b1110, 2 * W + 1, "neg_dvs");
        do_op(4'b1010, 4'b1101, 2 * W + 1, "both_neg");
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(1, 15));
            do_op(a, b, 2 * W + 1, "rand");
        end
    endtask

    task automatic test_ovf();
        do_op(4'b1000, 4'b1111, 2 * W + 1, "ovf");
        checks++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
        do_op(4'd6, 4'd3, 2 * W + 1, "after_ovf");
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", bus.ovf); end
        do_op(4'b1000, 4'd1, 2 * W + 1, "most_neg_by_1");
    endtask

    task automatic test_div_zero();
        do_op(4'd5, 4'd0, 1, "div_zero");
        checks++;
        if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", bus.div_zero); end
        do_op(4'b1011, 4'd0, 1, "div_zero_neg");
        do_op(4'd4, 4'd2, 2 * W + 1, "after_dz");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clock);
        bus.dvd   = 4'd3;
        bus.dvs   = 4'd2;
        bus.start = 1'b1;
        sb_q.push_back(model(4'd3, 4'd2));
        @(posedge clock);
        #1 bus.dvd = 4'd1;
        bus.dvs = 4'd1;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (n != 2 * W + 1) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d want %0d", n, 2 * W + 1);
        end
        checks += 2;
        if (bus.quo !== 4'b0001) begin errors++; $display("FAIL b2b_first_quo: got %b want 0001", bus.quo); end
        if (bus.rem !== 4'b0001) begin errors++; $display("FAIL b2b_first_rem: got %b want 0001", bus.rem); end
        sb_q.push_back(model(4'd1, 4'd1));
        @(posedge clock);
        #1 bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy); end
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (n != 2 * W + 1) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d want %0d", n, 2 * W + 1);
        end
        checks += 2;
        if (bus.quo !== 4'b0001) begin errors++; $display("FAIL b2b_second_quo: got %b want 0001", bus.quo); end
        if (bus.rem !== 4'b0000) begin errors++; $display("FAIL b2b_second_rem: got %b want 0000", bus.rem); end
        @(posedge clock);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        bus.dvd   = 4'd7;
        bus.dvs   = 4'd2;
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 checks += 6;
        if (bus.quo !== 4'b0000) begin errors++; $display("FAIL mid_rst_quo: got %b want 0000", bus.quo); end
        if (bus.rem !== 4'b0000) begin errors++; $display("FAIL mid_rst_rem: got %b want 0000", bus.rem); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", bus.done); end
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL mid_rst_dz: got %b want 0", bus.div_zero); end
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: got %b want 0", bus.ovf); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(posedge clock);
        #1 checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_quiet: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        do_op(4'd7, 4'd2, 2 * W + 1, "after_mid_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_ovf();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clock);
        #1 checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d outstanding want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
